// File: rtl/host_link_pkg.sv
// Shared types, default parameters and the XOR checksum helper for host_link.
package host_link_pkg;

    localparam int unsigned RX_BYTES_DEF    = 76;
    localparam int unsigned TX_BYTES_DEF    = 32;
    localparam int unsigned TX_REPEAT_DEF   = 1;
    localparam int unsigned CHECKSUM_EN_DEF = 1;
    localparam int unsigned RX_TIMEOUT_DEF  = 200000;

    localparam int unsigned XOR_MAX_BYTES = 256;
    localparam int unsigned XOR_W         = XOR_MAX_BYTES * 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ISSUE = 2'd1,
        TX_WAIT  = 2'd2,
        TX_DONE  = 2'd3
    } tx_state_t;

    // XOR of the low nbytes bytes of data; callers zero-extend to XOR_W.
    function automatic logic [7:0] xor_bytes(input logic [XOR_W-1:0] data,
                                             input int unsigned     nbytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int unsigned i = 0; i < XOR_MAX_BYTES; i++) begin
            if (i < nbytes) acc = acc ^ data[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/host_link_if.sv
// Byte-stream host link bundle: RX assembly side and TX serialiser side.
interface host_link_if
    import host_link_pkg::*;
#(
    parameter int unsigned RX_BYTES = RX_BYTES_DEF,
    parameter int unsigned TX_BYTES = TX_BYTES_DEF
);
    logic                  rx_enable;
    logic                  rx_byte_valid;
    logic [7:0]            rx_byte;
    logic [RX_BYTES*8-1:0] rx_block;
    logic                  rx_done;
    logic                  rx_error;
    logic                  rx_timeout;
    logic [7:0]            rx_count;

    logic                  tx_enable;
    logic [TX_BYTES*8-1:0] tx_payload;
    logic                  tx_byte_done;
    logic                  tx_dv;
    logic [7:0]            tx_byte;
    logic                  tx_done;

    modport slave (
        input  rx_enable, rx_byte_valid, rx_byte,
        output rx_block, rx_done, rx_error, rx_timeout, rx_count,
        input  tx_enable, tx_payload, tx_byte_done,
        output tx_dv, tx_byte, tx_done
    );

    modport master (
        output rx_enable, rx_byte_valid, rx_byte,
        input  rx_block, rx_done, rx_error, rx_timeout, rx_count,
        output tx_enable, tx_payload, tx_byte_done,
        input  tx_dv, tx_byte, tx_done
    );
endinterface

// File: rtl/host_link_tx.sv
// TX serialiser: snapshots the payload, then strobes each byte (plus checksum)
// TX_REPEAT times to the UART, waiting for its done strobe between bytes.
module host_link_tx
    import host_link_pkg::*;
#(
    parameter int unsigned TX_BYTES    = TX_BYTES_DEF,
    parameter int unsigned TX_REPEAT   = TX_REPEAT_DEF,
    parameter int unsigned CHECKSUM_EN = CHECKSUM_EN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  tx_enable,
    input  logic [TX_BYTES*8-1:0] tx_payload,
    input  logic                  tx_byte_done,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    output logic                  tx_done
);
    localparam int unsigned TXW    = TX_BYTES * 8;
    localparam int unsigned NBYTES = TX_BYTES + ((CHECKSUM_EN != 0) ? 1 : 0);
    localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
    localparam int unsigned REP_W  = 4;

    tx_state_t        state_q, state_d;
    logic [TXW-1:0]   shadow_q, shadow_d;
    logic [7:0]       ck_q, ck_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_done_q, tx_done_d;

    logic             last_rep_c;
    logic             last_byte_c;
    logic [7:0]       cur_byte_c;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= TX_IDLE;
            shadow_q  <= '0;
            ck_q      <= 8'h00;
            idx_q     <= '0;
            rep_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            ck_q      <= ck_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            tx_done_q <= tx_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        ck_d      = ck_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        tx_done_d = 1'b0;

        last_rep_c  = (rep_q == REP_W'(TX_REPEAT - 1));
        last_byte_c = (idx_q == IDX_W'(NBYTES - 1));

        // Index past the payload selects the checksum byte.
        cur_byte_c = ck_q;
        for (int unsigned i = 0; i < TX_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) cur_byte_c = shadow_q[i*8 +: 8];
        end

        case (state_q)
            TX_IDLE: begin
                if (tx_enable) begin
                    shadow_d = tx_payload;
                    ck_d     = (CHECKSUM_EN != 0) ? xor_bytes(XOR_W'(tx_payload), TX_BYTES) : 8'h00;
                    idx_d    = '0;
                    rep_d    = '0;
                    state_d  = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = cur_byte_c;
                state_d   = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_byte_done) begin
                    if (last_rep_c && last_byte_c) begin
                        state_d   = TX_DONE;
                        tx_done_d = 1'b1;
                    end else begin
                        state_d = TX_ISSUE;
                        if (last_rep_c) begin
                            rep_d = '0;
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end
            end
            TX_DONE: begin
                // Hold here until the requester lets go, so a held enable never resends.
                if (!tx_enable) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;
    assign tx_done = tx_done_q;

endmodule

// File: rtl/host_link.sv
// Host link top: RX frame assembler with XOR check and inter-byte timeout,
// plus the TX serialiser sub-module; the two paths are fully independent.
module host_link
    import host_link_pkg::*;
#(
    parameter int unsigned RX_BYTES    = RX_BYTES_DEF,
    parameter int unsigned TX_BYTES    = TX_BYTES_DEF,
    parameter int unsigned TX_REPEAT   = TX_REPEAT_DEF,
    parameter int unsigned CHECKSUM_EN = CHECKSUM_EN_DEF,
    parameter int unsigned RX_TIMEOUT  = RX_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_i,
    host_link_if.slave bus
);
    localparam int unsigned RXW  = RX_BYTES * 8;
    localparam int unsigned TO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;

    logic [RXW-1:0]  asm_q, asm_d;
    logic [RXW-1:0]  rx_block_q, rx_block_d;
    logic [7:0]      rx_count_q, rx_count_d;
    logic [7:0]      rx_xor_q, rx_xor_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            rx_done_q, rx_done_d;
    logic            rx_error_q, rx_error_d;
    logic            rx_timeout_q, rx_timeout_d;

    logic            accept_c;
    logic            ck_pend_c;
    logic            last_payload_c;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            asm_q        <= '0;
            rx_block_q   <= '0;
            rx_count_q   <= 8'h00;
            rx_xor_q     <= 8'h00;
            to_cnt_q     <= '0;
            rx_done_q    <= 1'b0;
            rx_error_q   <= 1'b0;
            rx_timeout_q <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            rx_block_q   <= rx_block_d;
            rx_count_q   <= rx_count_d;
            rx_xor_q     <= rx_xor_d;
            to_cnt_q     <= to_cnt_d;
            rx_done_q    <= rx_done_d;
            rx_error_q   <= rx_error_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    always_comb begin
        asm_d        = asm_q;
        rx_block_d   = rx_block_q;
        rx_count_d   = rx_count_q;
        rx_xor_d     = rx_xor_q;
        to_cnt_d     = to_cnt_q;
        rx_done_d    = 1'b0;
        rx_error_d   = 1'b0;
        rx_timeout_d = 1'b0;

        accept_c       = bus.rx_enable & bus.rx_byte_valid;
        // rx_count sitting at RX_BYTES means only the checksum byte is outstanding.
        ck_pend_c      = (CHECKSUM_EN != 0) && (rx_count_q == 8'(RX_BYTES));
        last_payload_c = (rx_count_q == 8'(RX_BYTES - 1));

        if (accept_c) begin
            to_cnt_d = '0;
            if (ck_pend_c) begin
                rx_done_d  = 1'b1;
                rx_count_d = 8'h00;
                rx_xor_d   = 8'h00;
                if (bus.rx_byte == rx_xor_q) rx_block_d = asm_q;
                else                         rx_error_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < RX_BYTES; i++) begin
                    if (rx_count_q == 8'(i)) asm_d[i*8 +: 8] = bus.rx_byte;
                end
                rx_xor_d   = rx_xor_q ^ bus.rx_byte;
                rx_count_d = rx_count_q + 8'd1;
                if ((CHECKSUM_EN == 0) && last_payload_c) begin
                    rx_done_d  = 1'b1;
                    rx_count_d = 8'h00;
                    rx_xor_d   = 8'h00;
                    rx_block_d = asm_d;
                end
            end
        end else if ((RX_TIMEOUT != 0) && (rx_count_q != 8'h00)) begin
            // Stall counter keeps running even while rx_enable is low.
            if (to_cnt_q == TO_W'(RX_TIMEOUT - 1)) begin
                rx_timeout_d = 1'b1;
                rx_count_d   = 8'h00;
                rx_xor_d     = 8'h00;
                to_cnt_d     = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    assign bus.rx_block   = rx_block_q;
    assign bus.rx_done    = rx_done_q;
    assign bus.rx_error   = rx_error_q;
    assign bus.rx_timeout = rx_timeout_q;
    assign bus.rx_count   = rx_count_q;

    host_link_tx #(
        .TX_BYTES    (TX_BYTES),
        .TX_REPEAT   (TX_REPEAT),
        .CHECKSUM_EN (CHECKSUM_EN)
    ) u_tx (
        .clk          (clk),
        .rst_i        (rst_i),
        .tx_enable    (bus.tx_enable),
        .tx_payload   (bus.tx_payload),
        .tx_byte_done (bus.tx_byte_done),
        .tx_dv        (bus.tx_dv),
        .tx_byte      (bus.tx_byte),
        .tx_done      (bus.tx_done)
    );

endmodule

// File: tb/tb_host_link.sv
// Directed bench for host_link: RX vector table, then timeout, TX frame,
// mid-frame reset and overlapping RX/TX sequences.
module tb_host_link;
    import host_link_pkg::*;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    host_link_if #(.RX_BYTES(4), .TX_BYTES(2)) bus ();

    host_link #(
        .RX_BYTES    (4),
        .TX_BYTES    (2),
        .TX_REPEAT   (2),
        .CHECKSUM_EN (1),
        .RX_TIMEOUT  (50)
    ) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [7:0]  b;
        logic [7:0]  cnt;
        logic        done;
        logic        err;
        logic [31:0] blk;
    } rx_vec_t;

    localparam int NVEC = 17;
    rx_vec_t vecs [NVEC];

    logic [7:0] tx_got [8];
    logic [7:0] tx_exp [6];
    logic [7:0] rx_cc  [4];
    int tx_n, done_cnt, done_at, rxd_at, rxd_cnt;
    logic rxd_err;

    task automatic send_rx(input logic [7:0] b);
        bus.rx_byte       = b;
        bus.rx_byte_valid = 1'b1;
        @(negedge clk);
        bus.rx_byte_valid = 1'b0;
    endtask

    // Drives one TX frame with a UART model answering 10 cycles after each strobe;
    // optionally feeds an RX frame whose checksum lands with the final byte_done.
    task automatic run_tx(input logic [15:0] pl, input bit with_rx, input int stop_at_dv);
        int  cd;
        int  tail;
        bit  spurious;
        cd = -1; tail = -1; spurious = 1'b0;
        tx_n = 0; done_cnt = 0; done_at = -1; rxd_at = -1; rxd_cnt = 0; rxd_err = 1'b0;
        bus.tx_payload = pl;
        bus.tx_enable  = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.tx_byte_done  = 1'b0;
            bus.rx_byte_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.tx_byte_done = 1'b1;
                    if (with_rx && tx_n == 6) begin
                        bus.rx_byte       = 8'h00;
                        bus.rx_byte_valid = 1'b1;
                    end
                end
            end else if (done_cnt > 0 && !spurious) begin
                spurious         = 1'b1;
                bus.tx_byte_done = 1'b1;
            end
            if (bus.tx_dv) begin
                if (tx_n < 8) tx_got[tx_n] = bus.tx_byte;
                tx_n++;
                cd = 10;
                if (tx_n == 1) bus.tx_payload = ~pl;
                if (with_rx && tx_n <= 4) begin
                    bus.rx_byte       = rx_cc[tx_n-1];
                    bus.rx_byte_valid = 1'b1;
                end
                if (tx_n == stop_at_dv) return;
            end
            if (bus.tx_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
                tail = 30;
            end
            if (bus.rx_done) begin
                rxd_cnt++;
                rxd_err = bus.rx_error;
                if (rxd_at < 0) rxd_at = cyc;
            end
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end
        end
        bus.tx_byte_done  = 1'b0;
        bus.rx_byte_valid = 1'b0;
    endtask

    task automatic check_tx_frame(input string tag);
        check({tag, "_strobes"}, 32'(tx_n), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("%s_byte%0d", tag, i), 32'(tx_got[i]), 32'(tx_exp[i]));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int to_k;

        // EF^BE = 51; payload bytes go low byte first.
        tx_exp[0] = 8'hEF; tx_exp[1] = 8'hEF; tx_exp[2] = 8'hBE;
        tx_exp[3] = 8'hBE; tx_exp[4] = 8'h51; tx_exp[5] = 8'h51;
        // 5A^A5^C3^3C = 00
        rx_cc[0] = 8'h5A; rx_cc[1] = 8'hA5; rx_cc[2] = 8'hC3; rx_cc[3] = 8'h3C;

        // XOR of 11,22,33,44 is 44; AA^55^66^77 is EE; 01^02^04^08 is 0F.
        vecs[0]  = '{1'b1, 8'h11, 8'd1, 1'b0, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 8'h22, 8'd2, 1'b0, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b0, 8'hFF, 8'd2, 1'b0, 1'b0, 32'h00000000};
        vecs[3]  = '{1'b1, 8'h33, 8'd3, 1'b0, 1'b0, 32'h00000000};
        vecs[4]  = '{1'b1, 8'h44, 8'd4, 1'b0, 1'b0, 32'h00000000};
        vecs[5]  = '{1'b1, 8'h44, 8'd0, 1'b1, 1'b0, 32'h44332211};
        vecs[6]  = '{1'b1, 8'hAA, 8'd1, 1'b0, 1'b0, 32'h44332211};
        vecs[7]  = '{1'b1, 8'h55, 8'd2, 1'b0, 1'b0, 32'h44332211};
        vecs[8]  = '{1'b1, 8'h66, 8'd3, 1'b0, 1'b0, 32'h44332211};
        vecs[9]  = '{1'b1, 8'h77, 8'd4, 1'b0, 1'b0, 32'h44332211};
        vecs[10] = '{1'b1, 8'h01, 8'd0, 1'b1, 1'b1, 32'h44332211};
        vecs[11] = '{1'b0, 8'hEE, 8'd0, 1'b0, 1'b0, 32'h44332211};
        vecs[12] = '{1'b1, 8'h01, 8'd1, 1'b0, 1'b0, 32'h44332211};
        vecs[13] = '{1'b1, 8'h02, 8'd2, 1'b0, 1'b0, 32'h44332211};
        vecs[14] = '{1'b1, 8'h04, 8'd3, 1'b0, 1'b0, 32'h44332211};
        vecs[15] = '{1'b1, 8'h08, 8'd4, 1'b0, 1'b0, 32'h44332211};
        vecs[16] = '{1'b1, 8'h0F, 8'd0, 1'b1, 1'b0, 32'h08040201};

        rst_i             = 1'b1;
        bus.rx_enable     = 1'b0;
        bus.rx_byte_valid = 1'b0;
        bus.rx_byte       = 8'h00;
        bus.tx_enable     = 1'b0;
        bus.tx_payload    = 16'h0000;
        bus.tx_byte_done  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_rx_block", bus.rx_block, 32'h0);
        check("rst_rx_count", 32'(bus.rx_count), 32'h0);
        check("rst_pulses", {27'h0, bus.rx_done, bus.rx_error, bus.rx_timeout, bus.tx_dv, bus.tx_done}, 32'h0);
        check("rst_tx_byte", 32'(bus.tx_byte), 32'h0);
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_pulses", {27'h0, bus.rx_done, bus.rx_error, bus.rx_timeout, bus.tx_dv, bus.tx_done}, 32'h0);

        // RX vector table
        for (int i = 0; i < NVEC; i++) begin
            bus.rx_enable     = vecs[i].en;
            bus.rx_byte       = vecs[i].b;
            bus.rx_byte_valid = 1'b1;
            @(negedge clk);
            bus.rx_byte_valid = 1'b0;
            check($sformatf("vec%0d_count", i), 32'(bus.rx_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_done", i), 32'(bus.rx_done), 32'(vecs[i].done));
            check($sformatf("vec%0d_error", i), 32'(bus.rx_error), 32'(vecs[i].err));
            check($sformatf("vec%0d_block", i), bus.rx_block, vecs[i].blk);
            check($sformatf("vec%0d_timeout", i), 32'(bus.rx_timeout), 32'h0);
        end

        // RX timeout with rx_enable dropped mid-frame
        bus.rx_enable = 1'b1;
        send_rx(8'hAA);
        send_rx(8'hBB);
        bus.rx_enable = 1'b0;
        check("to_pre_count", 32'(bus.rx_count), 32'd2);
        to_k = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.rx_timeout) begin
                to_k = k;
                break;
            end
        end
        check("to_latency", 32'(to_k), 32'd50);
        check("to_count_cleared", 32'(bus.rx_count), 32'd0);
        @(negedge clk);
        check("to_single_pulse", 32'(bus.rx_timeout), 32'd0);
        bus.rx_enable = 1'b1;
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
        bus.rx_byte = 8'h44;
        bus.rx_byte_valid = 1'b1;
        @(negedge clk);
        bus.rx_byte_valid = 1'b0;
        check("to_after_done", 32'(bus.rx_done), 32'd1);
        check("to_after_error", 32'(bus.rx_error), 32'd0);
        check("to_after_block", bus.rx_block, 32'h44332211);

        // Stray tx_byte_done while idle
        bus.tx_byte_done = 1'b1;
        @(negedge clk);
        bus.tx_byte_done = 1'b0;
        @(negedge clk);
        check("idle_stray_done_dv", 32'(bus.tx_dv), 32'd0);
        check("idle_stray_done_state", 32'(dut.u_tx.state_q), 32'(TX_IDLE));

        // TX frame with enable held and payload changed mid-frame
        run_tx(16'hBEEF, 1'b0, 0);
        check_tx_frame("tx1");
        check("tx1_done_state", 32'(dut.u_tx.state_q), 32'(TX_DONE));
        bus.tx_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("tx1_back_idle", 32'(dut.u_tx.state_q), 32'(TX_IDLE));

        // Reset in the middle of a TX frame and a partial RX frame
        send_rx(8'h77);
        run_tx(16'hBEEF, 1'b0, 3);
        check("rst_mid_third_byte", 32'(tx_got[2]), 32'hBE);
        rst_i         = 1'b1;
        bus.tx_enable = 1'b0;
        @(negedge clk);
        check("rst_mid_dv", 32'(bus.tx_dv), 32'd0);
        check("rst_mid_state", 32'(dut.u_tx.state_q), 32'(TX_IDLE));
        check("rst_mid_rx_count", 32'(bus.rx_count), 32'd0);
        check("rst_mid_rx_block", bus.rx_block, 32'h0);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_mid_release_pulses", {27'h0, bus.rx_done, bus.rx_error, bus.rx_timeout, bus.tx_dv, bus.tx_done}, 32'h0);
        run_tx(16'hBEEF, 1'b0, 0);
        check_tx_frame("tx2");
        bus.tx_enable = 1'b0;
        repeat (2) @(negedge clk);

        // Overlapping RX and TX frames finishing on the same edge
        run_tx(16'hBEEF, 1'b1, 0);
        check_tx_frame("cc");
        check("cc_rx_done_pulses", 32'(rxd_cnt), 32'd1);
        check("cc_rx_error", 32'(rxd_err), 32'd0);
        check("cc_same_cycle", 32'(rxd_at), 32'(done_at));
        check("cc_rx_block", bus.rx_block, 32'h3CC3A55A);
        bus.tx_enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
